// File: rtl/pio_in_capture.sv
// Avalon-MM input PIO: synchronizes external pins, captures edges, raises a masked irq.
// Optional per-bit debounce filter enabled with `define PIO_IN_DEBOUNCE_EN.
module pio_in_capture #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [1:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic             avs_readdatavalid,
    output logic             irq,
    input  logic [WIDTH-1:0] pins_export
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_val;
    logic [WIDTH-1:0] filt_val;
    logic [WIDTH-1:0] prev_val;
    logic [WIDTH-1:0] cap;
    logic [WIDTH-1:0] mask;
    logic [1:0]       edge_sel;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] set;
    logic [WIDTH-1:0] clr;
    logic [31:0]      rd_mux;
    logic [31:0]      unused_wdata;

    assign unused_wdata = avs_writedata;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= pins_export;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync_val = sync_q[SYNC_STAGES-1];

`ifdef PIO_IN_DEBOUNCE_EN
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt [WIDTH];

    // A bit is accepted only after staying different from filt_val long enough
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            filt_val <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_val[i] == filt_val[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    filt_val[i] <= sync_val[i];
                    cnt[i]      <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    localparam int unused_debounce = DEBOUNCE_CYCLES;

    assign filt_val = sync_val;
`endif

    assign rise = filt_val & ~prev_val;
    assign fall = ~filt_val & prev_val;

    always_comb begin
        set = rise | fall;
        case (edge_sel)
            2'd0:    set = rise;
            2'd1:    set = fall;
            default: set = rise | fall;
        endcase
    end

    assign clr = (avs_write && avs_address == 2'd2)
               ? avs_writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            prev_val <= '0;
            cap      <= '0;
            mask     <= '0;
            edge_sel <= '0;
            irq      <= 1'b0;
        end else begin
            prev_val <= filt_val;
            // set is OR-ed after the clear so a coincident edge survives
            cap      <= (cap & ~clr) | set;
            irq      <= |(cap & mask);
            if (avs_write && avs_address == 2'd1) begin
                mask <= avs_writedata[WIDTH-1:0];
            end
            if (avs_write && avs_address == 2'd3) begin
                edge_sel <= avs_writedata[1:0];
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        unique case (avs_address)
            2'd0: rd_mux[WIDTH-1:0] = filt_val;
            2'd1: rd_mux[WIDTH-1:0] = mask;
            2'd2: rd_mux[WIDTH-1:0] = cap;
            2'd3: rd_mux[1:0]       = edge_sel;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            avs_readdata      <= '0;
            avs_readdatavalid <= 1'b0;
        end else begin
            avs_readdatavalid <= avs_read;
            if (avs_read) begin
                avs_readdata <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_pio_in_capture.sv
// Directed bench for pio_in_capture: register table plus multi-cycle corner sequences.
// Build with PIO_IN_DEBOUNCE_EN to add the debounce checks (DEBOUNCE_CYCLES=8).
module tb_pio_in_capture;

    localparam int SYNC = 2;
    localparam int DB   = 8;
`ifdef PIO_IN_DEBOUNCE_EN
    localparam int EXTRA = DB;
`else
    localparam int EXTRA = 0;
`endif
    localparam int LAT = SYNC + EXTRA;
    localparam int SETTLE = LAT + 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic        irq;
    logic [7:0]  pins = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pio_in_capture #(
        .WIDTH(8),
        .SYNC_STAGES(SYNC),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk_clk(clk),
        .reset_reset_n(rst_n),
        .avs_address(address),
        .avs_read(read),
        .avs_write(write),
        .avs_writedata(writedata),
        .avs_readdata(readdata),
        .avs_readdatavalid(readdatavalid),
        .irq(irq),
        .pins_export(pins)
    );

    typedef struct {
        logic [7:0]  pins;
        int          settle;
        logic        wr;
        logic [1:0]  waddr;
        logic [31:0] wdata;
        logic [1:0]  raddr;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        tick(1);
        write     = 1'b0;
    endtask

    task automatic rd_chk(input logic [1:0] a, input logic [31:0] exp,
                          input string nm);
        address = a;
        read    = 1'b1;
        tick(1);
        read    = 1'b0;
        check({nm, " valid"}, 32'(readdatavalid), 32'd1);
        check({nm, " data"}, readdata, exp);
        tick(1);
        check({nm, " valid drop"}, 32'(readdatavalid), 32'd0);
    endtask

    task automatic add(input logic [7:0] p, input int s, input logic w,
                       input logic [1:0] wa, input logic [31:0] wd,
                       input logic [1:0] ra, input logic [31:0] er,
                       input logic ei);
        vec_t v;
        v = '{p, s, w, wa, wd, ra, er, ei};
        tbl.push_back(v);
    endtask

    initial begin
        // pins settle wr waddr wdata raddr exp_rd exp_irq
        add(8'h00, 0, 0, 2'd0, 32'h0, 2'd0, 32'h00, 0);
        add(8'h00, 0, 0, 2'd0, 32'h0, 2'd1, 32'h00, 0);
        add(8'h00, 0, 0, 2'd0, 32'h0, 2'd2, 32'h00, 0);
        add(8'h00, 0, 0, 2'd0, 32'h0, 2'd3, 32'h00, 0);
        add(8'h00, 0, 1, 2'd1, 32'h01, 2'd1, 32'h01, 0);
        add(8'h01, SETTLE, 0, 2'd0, 32'h0, 2'd2, 32'h01, 1);
        add(8'h00, SETTLE, 0, 2'd0, 32'h0, 2'd2, 32'h01, 1);
        add(8'h00, 0, 0, 2'd0, 32'h0, 2'd0, 32'h00, 1);
        add(8'h00, 0, 1, 2'd2, 32'h01, 2'd2, 32'h00, 0);
        add(8'h00, 0, 1, 2'd3, 32'h02, 2'd3, 32'h02, 0);
        add(8'h08, SETTLE, 0, 2'd0, 32'h0, 2'd2, 32'h08, 0);
        add(8'h08, 0, 0, 2'd0, 32'h0, 2'd0, 32'h08, 0);
        add(8'h08, 0, 1, 2'd2, 32'h08, 2'd2, 32'h00, 0);
        add(8'h00, SETTLE, 0, 2'd0, 32'h0, 2'd2, 32'h08, 0);
        add(8'h00, 0, 1, 2'd2, 32'h08, 2'd2, 32'h00, 0);
        add(8'h00, 0, 1, 2'd3, 32'h01, 2'd3, 32'h01, 0);
        add(8'h08, SETTLE, 0, 2'd0, 32'h0, 2'd2, 32'h00, 0);
        add(8'h00, SETTLE, 0, 2'd0, 32'h0, 2'd2, 32'h08, 0);
        add(8'h00, 0, 1, 2'd2, 32'hFF, 2'd2, 32'h00, 0);
        add(8'h00, 0, 1, 2'd3, 32'h00, 2'd3, 32'h00, 0);
        add(8'h00, 0, 1, 2'd0, 32'hFF, 2'd0, 32'h00, 0);
        add(8'h00, 0, 1, 2'd1, 32'hFFFFFFFF, 2'd1, 32'hFF, 0);
        add(8'h00, 0, 1, 2'd1, 32'h00, 2'd1, 32'h00, 0);

        tick(2);
        check("reset readdata", readdata, 32'h0);
        check("reset valid", 32'(readdatavalid), 32'd0);
        check("reset irq", 32'(irq), 32'd0);
        rst_n = 1'b1;
        tick(1);

        for (int i = 0; i < tbl.size(); i++) begin
            pins = tbl[i].pins;
            tick(tbl[i].settle);
            if (tbl[i].wr) wr(tbl[i].waddr, tbl[i].wdata);
            rd_chk(tbl[i].raddr, tbl[i].exp_rd, $sformatf("vec%0d", i));
            check($sformatf("vec%0d irq", i), 32'(irq), 32'(tbl[i].exp_irq));
        end

        // irq latency from pin change, rising edge, mask bit 0
        wr(2'd1, 32'h01);
        pins = 8'h01;
        for (int k = 1; k <= LAT + 2; k++) begin
            tick(1);
            check($sformatf("irq lat %0d", k), 32'(irq),
                  32'(k == LAT + 2));
        end
        pins = 8'h00;
        tick(SETTLE);
        wr(2'd2, 32'hFF);
        wr(2'd1, 32'h00);

        // write-one-to-clear and set-beats-clear
        pins = 8'h05;
        tick(SETTLE);
        rd_chk(2'd2, 32'h05, "w1c start");
        wr(2'd2, 32'h04);
        rd_chk(2'd2, 32'h01, "w1c clear bit2");
        wr(2'd2, 32'h00);
        rd_chk(2'd2, 32'h01, "w1c zero write");
        pins = 8'h00;
        tick(SETTLE);
        pins = 8'h01;
        tick(LAT);
        wr(2'd2, 32'h01);
        rd_chk(2'd2, 32'h01, "set beats clear");
        wr(2'd2, 32'hFF);
        rd_chk(2'd2, 32'h00, "w1c all");
        pins = 8'h00;
        tick(SETTLE);

        // mask gating
        pins = 8'h80;
        tick(SETTLE);
        check("mask0 irq", 32'(irq), 32'd0);
        wr(2'd1, 32'h80);
        check("mask set irq not yet", 32'(irq), 32'd0);
        tick(1);
        check("mask set irq", 32'(irq), 32'd1);
        wr(2'd1, 32'h00);
        check("mask clr irq not yet", 32'(irq), 32'd1);
        tick(1);
        check("mask clr irq", 32'(irq), 32'd0);
        pins = 8'h00;
        tick(SETTLE);
        wr(2'd2, 32'hFF);

        // simultaneous read and write returns the old value
        address   = 2'd1;
        writedata = 32'h5A;
        read      = 1'b1;
        write     = 1'b1;
        tick(1);
        read  = 1'b0;
        write = 1'b0;
        check("rw valid", 32'(readdatavalid), 32'd1);
        check("rw old data", readdata, 32'h00);
        tick(1);
        rd_chk(2'd1, 32'h5A, "rw new data");

        // back-to-back reads, then readdata hold
        wr(2'd3, 32'h02);
        address = 2'd3;
        read    = 1'b1;
        tick(1);
        check("b2b valid0", 32'(readdatavalid), 32'd1);
        check("b2b data0", readdata, 32'h02);
        address = 2'd1;
        tick(1);
        read = 1'b0;
        check("b2b valid1", 32'(readdatavalid), 32'd1);
        check("b2b data1", readdata, 32'h5A);
        tick(1);
        check("b2b valid end", 32'(readdatavalid), 32'd0);
        tick(2);
        check("readdata hold", readdata, 32'h5A);
        wr(2'd3, 32'h00);

        // reset mid-read with a pin held high through release
        pins    = 8'h01;
        address = 2'd1;
        read    = 1'b1;
        @(posedge clk);
        #1;
        read = 1'b0;
        check("pre-reset valid", 32'(readdatavalid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid reset valid", 32'(readdatavalid), 32'd0);
        check("mid reset data", readdata, 32'h0);
        check("mid reset irq", 32'(irq), 32'd0);
        tick(3);
        rst_n = 1'b1;
        rd_chk(2'd2, 32'h00, "post reset cap");
        tick(EXTRA + 2);
        rd_chk(2'd2, 32'h01, "release edge");
        rd_chk(2'd1, 32'h00, "post reset mask");
        pins = 8'h00;
        tick(SETTLE);
        wr(2'd2, 32'hFF);

`ifdef PIO_IN_DEBOUNCE_EN
        // short glitch rejected, long pulse accepted
        pins = 8'h04;
        tick(5);
        pins = 8'h00;
        tick(20);
        rd_chk(2'd0, 32'h00, "glitch data");
        rd_chk(2'd2, 32'h00, "glitch cap");
        pins = 8'h04;
        tick(SYNC + DB - 1);
        rd_chk(2'd0, 32'h00, "db before");
        rd_chk(2'd0, 32'h04, "db after");
        tick(20 - (SYNC + DB) - 3);
        pins = 8'h00;
        rd_chk(2'd2, 32'h04, "db cap");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
